// File: rtl/sparse_act_sel.sv
// sparse_act_sel: latches a group of N activations, then gathers GROUP of them
// one per sparse index into a registered valid/ready output stage.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and a producer holding valid keeps
// its payload stable until the transfer. act_ready is high only in IDLE;
// idx_ready is high only in SEL while the output register is empty or being
// drained in the same cycle.
module sparse_act_sel #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int GROUP = 2,
    parameter int IW    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*DW-1:0] act_in,
    input  logic            act_valid,
    output logic            act_ready,
    input  logic [IW-1:0]   idx_in,
    input  logic            idx_zero,
    input  logic            idx_valid,
    output logic            idx_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEL  = 1'b1;

    // cnt needs at least one bit even when GROUP is 1
    localparam int            CW       = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(GROUP - 1);

    logic [0:0]      state;
    logic [CW-1:0]   cnt;
    logic [N*DW-1:0] act_reg;
    logic            act_hs;
    logic            idx_hs;
    logic            cnt_last;
    logic            idx_oob;
    logic [DW-1:0]   sel_data;
    logic [DW-1:0]   next_data;

    assign act_ready = (state == S_IDLE);
    assign idx_ready = (state == S_SEL) && (!out_valid || out_ready);
    assign act_hs    = act_valid && act_ready;
    assign idx_hs    = idx_valid && idx_ready;
    assign cnt_last  = (cnt == CNT_LAST);
    // only reachable when N is not a power of two
    assign idx_oob   = (32'(idx_in) >= 32'(N));

    // N-way lane mux on the latched group; no lane matches an out-of-range index
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (idx_in == IW'(k)) begin
                sel_data = act_reg[k*DW +: DW];
            end
        end
        next_data = (idx_zero || idx_oob) ? '0 : sel_data;
    end

    // group FSM: IDLE latches activations, SEL counts indices to the group end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            act_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (act_hs) begin
                        act_reg <= act_in;
                        cnt     <= '0;
                        state   <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (idx_hs) begin
                        if (cnt_last) begin
                            cnt   <= '0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // output register: reload on an index, otherwise empty when drained
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (idx_hs) begin
            out_data  <= next_data;
            out_last  <= cnt_last;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // sticky flag for a non-pruned index beyond the last lane
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (idx_hs && !idx_zero && idx_oob) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sparse_act_sel.sv
// tb_sparse_act_sel: directed and randomized checks of sparse_act_sel against
// a behavioural model and a beat scoreboard; a second N=3 build covers the
// out-of-range index path.
module tb_sparse_act_sel;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int GROUP = 2;
    localparam int IW    = 2;
    localparam int W     = DW + 1;
    localparam int N3    = 3;

    // ---------------- clock ----------------
    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- main DUT (N=4) ----------------
    logic            rst;
    logic [N*DW-1:0] act_in;
    logic            act_valid;
    logic            act_ready;
    logic [IW-1:0]   idx_in;
    logic            idx_zero;
    logic            idx_valid;
    logic            idx_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;
    logic            err;

    sparse_act_sel #(.N(N), .DW(DW), .GROUP(GROUP)) dut (
        .clk(clk), .rst(rst),
        .act_in(act_in), .act_valid(act_valid), .act_ready(act_ready),
        .idx_in(idx_in), .idx_zero(idx_zero), .idx_valid(idx_valid), .idx_ready(idx_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .err(err)
    );

    // ---------------- N=3 DUT ----------------
    logic             rst_3;
    logic [N3*DW-1:0] act_in_3;
    logic             act_valid_3;
    logic             act_ready_3;
    logic [1:0]       idx_in_3;
    logic             idx_zero_3;
    logic             idx_valid_3;
    logic             idx_ready_3;
    logic [DW-1:0]    out_data_3;
    logic             out_last_3;
    logic             out_valid_3;
    logic             out_ready_3;
    logic             err_3;

    sparse_act_sel #(.N(N3), .DW(DW), .GROUP(GROUP)) dut3 (
        .clk(clk), .rst(rst_3),
        .act_in(act_in_3), .act_valid(act_valid_3), .act_ready(act_ready_3),
        .idx_in(idx_in_3), .idx_zero(idx_zero_3), .idx_valid(idx_valid_3), .idx_ready(idx_ready_3),
        .out_data(out_data_3), .out_last(out_last_3), .out_valid(out_valid_3), .out_ready(out_ready_3),
        .err(err_3)
    );

    // ---------------- scoreboard and model ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    bit            m_sel;        // a group is latched and indices are being taken
    int            m_done;       // indices already taken from the current group
    logic [DW-1:0] m_acts [N];
    bit            m_ov;
    bit            m_ol;
    logic [DW-1:0] m_od;
    bit            m_err;
    int            groups_done = 0;
    int            beats_seen  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // advance the model across one rising edge using the inputs now applied
    task automatic model_update();
        bit            act_hs;
        bit            idx_hs;
        logic [DW-1:0] val;
        logic [W-1:0]  beat;
        if (rst) begin
            m_sel  = 0;
            m_done = 0;
            m_ov   = 0;
            m_ol   = 0;
            m_od   = '0;
            m_err  = 0;
            for (int k = 0; k < N; k++) m_acts[k] = '0;
            exp_q.delete();
            return;
        end
        act_hs = !m_sel && act_valid;
        idx_hs = m_sel && idx_valid && (!m_ov || out_ready);
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_stream: got unexpected beat 0x%0h, required none at %0t", out_data, $time);
            end else begin
                beat = exp_q.pop_front();
                beats_seen++;
                if ({out_last, out_data} !== beat) begin
                    errors++;
                    $display("FAIL beat_stream: got 0x%0h expected 0x%0h at %0t", {out_last, out_data}, beat, $time);
                end
            end
        end
        if (m_ov && out_ready) m_ov = 0;
        if (idx_hs) begin
            if (idx_zero) val = '0;
            else if (int'(idx_in) >= N) begin
                val   = '0;
                m_err = 1;
            end else val = m_acts[idx_in];
            m_od = val;
            m_ol = (m_done == GROUP - 1);
            m_ov = 1;
            exp_q.push_back({m_ol, val});
            m_done++;
            if (m_done == GROUP) begin
                m_sel  = 0;
                m_done = 0;
                groups_done++;
            end
        end
        if (act_hs) begin
            for (int k = 0; k < N; k++) m_acts[k] = act_in[k*DW +: DW];
            m_done = 0;
            m_sel  = 1;
        end
    endtask

    task automatic compare();
        chk("act_ready", act_ready, !m_sel);
        chk("idx_ready", idx_ready, m_sel && (!m_ov || out_ready));
        chk("out_valid", out_valid, m_ov);
        chk("out_data",  out_data,  m_od);
        chk("out_last",  out_last,  m_ol);
        chk("err",       err,       m_err);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic tick3();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        act_valid = 0;
        act_in    = '0;
        idx_valid = 0;
        idx_zero  = 0;
        idx_in    = '0;
    endtask

    task automatic set_random();
        act_valid = 1'($urandom_range(0, 1));
        act_in    = $urandom();
        idx_valid = ($urandom_range(0, 3) != 0);
        idx_in    = IW'($urandom_range(0, 3));
        idx_zero  = ($urandom_range(0, 3) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int g0;
        int cyc;
        rst = 1;
        set_idle();
        out_ready   = 0;
        rst_3       = 1;
        act_in_3    = '0;
        act_valid_3 = 0;
        idx_in_3    = '0;
        idx_zero_3  = 0;
        idx_valid_3 = 0;
        out_ready_3 = 1;
        @(negedge clk);

        // reset with inputs toggling
        repeat (2) begin
            set_random();
            rst = 1;
            tick();
        end
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_err",       err,       0);
        chk("rst_act_ready", act_ready, 1);
        chk("rst_idx_ready", idx_ready, 0);
        rst = 0;
        set_idle();
        out_ready = 1;
        tick();

        // basic 2:4 gather
        act_in = 32'h44332211;
        act_valid = 1;
        tick();
        act_valid = 0;
        idx_valid = 1;
        idx_in = 2;
        tick();
        chk("basic_data0", out_data, 8'h33);
        chk("basic_last0", out_last, 0);
        chk("basic_valid0", out_valid, 1);
        idx_in = 0;
        tick();
        chk("basic_data1", out_data, 8'h11);
        chk("basic_last1", out_last, 1);
        chk("basic_act_ready", act_ready, 1);
        idx_valid = 0;
        tick();

        // pruned index followed by backpressure
        out_ready = 0;
        act_valid = 1;
        tick();
        act_valid = 0;
        idx_valid = 1;
        idx_zero = 1;
        idx_in = 1;
        tick();
        chk("bp_data0", out_data, 8'h00);
        idx_zero = 0;
        idx_in = 3;
        repeat (3) begin
            tick();
            chk("bp_stall_data",  out_data,  8'h00);
            chk("bp_stall_ready", idx_ready, 0);
            chk("bp_stall_valid", out_valid, 1);
        end
        out_ready = 1;
        tick();
        chk("bp_data1", out_data, 8'h44);
        chk("bp_last1", out_last, 1);
        idx_valid = 0;
        tick();
        chk("bp_drained", out_valid, 0);

        // randomized back-to-back groups
        g0 = groups_done;
        cyc = 0;
        while ((groups_done - g0 < 8) && (cyc < 3000)) begin
            set_random();
            tick();
            cyc++;
        end
        chk("random_groups_done", (groups_done - g0 >= 8), 1);

        // reset in the middle of a group
        set_idle();
        rst = 1;
        tick();
        rst = 0;
        tick();
        act_in = 32'hA0B0C0D0;
        act_valid = 1;
        tick();
        act_valid = 0;
        out_ready = 0;
        idx_valid = 1;
        idx_in = 1;
        tick();
        chk("midrst_data0", out_data, 8'hC0);
        idx_valid = 0;
        rst = 1;
        tick();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_act_ready", act_ready, 1);
        chk("midrst_idx_ready", idx_ready, 0);
        rst = 0;
        out_ready = 1;
        act_in = 32'h01020304;
        act_valid = 1;
        tick();
        act_valid = 0;
        idx_valid = 1;
        idx_in = 3;
        tick();
        chk("fresh_data0", out_data, 8'h01);
        chk("fresh_last0", out_last, 0);
        idx_zero = 1;
        tick();
        chk("fresh_data1", out_data, 8'h00);
        chk("fresh_last1", out_last, 1);
        set_idle();
        tick();

        // N=3 build: out-of-range index and sticky err
        rst_3 = 1;
        tick3();
        rst_3 = 0;
        chk("n3_rst_err", err_3, 0);
        act_in_3 = 24'h332211;
        act_valid_3 = 1;
        tick3();
        act_valid_3 = 0;
        idx_valid_3 = 1;
        idx_in_3 = 3;
        tick3();
        chk("n3_oob_data", out_data_3, 8'h00);
        chk("n3_oob_err", err_3, 1);
        chk("n3_oob_valid", out_valid_3, 1);
        idx_in_3 = 1;
        tick3();
        chk("n3_data1", out_data_3, 8'h22);
        chk("n3_last1", out_last_3, 1);
        chk("n3_err_hold1", err_3, 1);
        idx_valid_3 = 0;
        act_in_3 = 24'h665544;
        act_valid_3 = 1;
        tick3();
        act_valid_3 = 0;
        idx_valid_3 = 1;
        idx_in_3 = 2;
        tick3();
        chk("n3_g2_data0", out_data_3, 8'h66);
        chk("n3_err_hold2", err_3, 1);
        idx_in_3 = 0;
        tick3();
        chk("n3_g2_data1", out_data_3, 8'h44);
        chk("n3_err_hold3", err_3, 1);
        idx_valid_3 = 0;
        rst_3 = 1;
        tick3();
        rst_3 = 0;
        chk("n3_err_cleared", err_3, 0);
        act_in_3 = 24'h998877;
        act_valid_3 = 1;
        tick3();
        act_valid_3 = 0;
        idx_valid_3 = 1;
        idx_zero_3 = 1;
        idx_in_3 = 3;
        tick3();
        chk("n3_pruned_data", out_data_3, 8'h00);
        chk("n3_pruned_no_err", err_3, 0);
        idx_zero_3 = 0;
        idx_in_3 = 2;
        tick3();
        chk("n3_g3_data1", out_data_3, 8'h99);
        chk("n3_g3_err", err_3, 0);
        idx_valid_3 = 0;
        tick3();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sparse_act_sel.md
# sparse_act_sel

Parametrised, handshaked successor to the fixed 4-input activation mux. It latches one group of `N` activations, then consumes `GROUP` sparse indices from the weight-metadata stream and emits one selected activation per index through a registered output stage. It sits between the activation buffer and the PE multiplier input, and implements N:M structured-sparsity activation gathering (default 2:4).

## Interface
Parameters:
- `N`, 4: activations per group (≥2).
- `DW`, 8: activation width in bits.
- `GROUP`, 2: indices consumed per activation group (≥1).
- `IW`, `$clog2(N)`: index width (derived; do not override).

Ports:
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `act_in`, in, N*DW: packed activations; lane k is `act_in[k*DW +: DW]`.
- `act_valid`, in, 1: activation group valid.
- `act_ready`, out, 1: block can latch a group.
- `idx_in`, in, IW: lane select.
- `idx_zero`, in, 1: pruned entry; force output to 0, ignore `idx_in`.
- `idx_valid`, in, 1: index valid.
- `idx_ready`, out, 1: index accepted this cycle when high with `idx_valid`.
- `out_data`, out, DW: selected activation (registered).
- `out_last`, out, 1: marks the output of the final index of a group.
- `out_valid`, out, 1: output valid.
- `out_ready`, in, 1: downstream accept.
- `err`, out, 1: sticky out-of-range index flag.

## Operation
- There are two states, IDLE and SEL.
- IDLE:
  - `act_ready`=1 and `idx_ready`=0.
  - On an `act_valid`&&`act_ready` handshake, latch `act_in` into an internal N*DW register, clear `cnt` to 0, and go to SEL.
- SEL:
  - `act_ready`=0 and `idx_ready` = !`out_valid` || `out_ready`.
  - On an index handshake, load the output register:
    - `out_data` = 0 if `idx_zero`;
    - else `out_data` = 0 if `idx_in` ≥ N, and set `err`;
    - else `out_data` = lane `idx_in`.
  - `out_last` = (`cnt` == GROUP-1). Then increment `cnt`.
  - When `cnt` == GROUP-1 at the handshake, return to IDLE and reset `cnt` to 0.
- Output stage:
  - `out_valid` sets on an index handshake.
  - `out_valid` clears on `out_ready` when there is no simultaneous index handshake.
  - Data holds stable while `out_valid` && !`out_ready`.
- `err` is sticky until `rst`. It can only fire when N is not a power of two.
- Selection is a plain N-way mux on the latched register. There is no arithmetic.

## Timing
- Reset values:
  - state = IDLE, `cnt`=0, activation register = 0.
  - `out_data`=0, `out_last`=0, `out_valid`=0, `err`=0.
  - So `act_ready`=1 and `idx_ready`=0 in the first cycle after reset.
- Latency:
  - Index handshake in cycle t gives `out_valid`/`out_data` in cycle t+1.
  - Activation handshake in cycle t makes `idx_ready` possible in cycle t+1.
- Throughput is one index per cycle while `out_ready`=1.
- Group turnaround:
  - A last-index handshake in cycle t gives `act_ready`=1 in cycle t+1.
  - The minimum period per group is GROUP+1 cycles.
- Backpressure: `out_valid`=1 with `out_ready`=0 forces `idx_ready`=0. No data is lost and no index is consumed.
- Simultaneous output drain and index handshake in the same cycle: the register reloads and `out_valid` stays 1.
- A new group can be latched in IDLE while the last output of the previous group is still stalled. The latched activations do not disturb the pending `out_data`.
- `idx_valid` while in IDLE is ignored (not consumed).
- `act_valid` while in SEL is ignored (not consumed).
- `rst` mid-group: synchronous return to reset values on the next edge.
  - The pending output is dropped.
  - The partial group is discarded.
- GROUP=1: every index is last, and the block alternates IDLE/SEL.

## Test plan
- **Reset:** assert `rst` 2 cycles with all inputs toggling. Require `out_valid`=0, `out_data`=0, `err`=0, `act_ready`=1, `idx_ready`=0.
- **Basic 2:4:** N=4, DW=8, `act_in` lanes = {0x11,0x22,0x33,0x44}; indices 2 then 0, `out_ready`=1.
  - Outputs 0x33 (`out_last`=0), then 0x11 (`out_last`=1) on consecutive cycles.
  - `act_ready`=1 the cycle after the second index.
- **Pruned and backpressure:** index with `idx_zero`=1, then index 3, with `out_ready` held 0 for 3 cycles.
  - `out_data`=0x00 held stable and `idx_ready`=0 throughout the stall.
  - On release: 0x00 accepted, then 0x44.
- **Out of range:** N=3 build, `idx_in`=3. Output 0x00 and `err`=1; `err` stays 1 over later valid groups until `rst`.
- **Back-to-back groups:** 8 groups with random lanes/indices and random `out_ready`. The output stream matches the reference model, with `out_last` every 2nd beat and no dropped or duplicated beats.
- **Reset mid-group:** assert `rst` after the first index of a group.
  - Next cycle is IDLE with `out_valid`=0.
  - A fresh group then produces correct outputs.
